// File: rtl/pingpong_pkg.sv
// Shared types and constants for the ping-pong counter generator.
// Holds the run-mode enum, direction encodings and the config values
// restored by reset (upper bound resets to all-ones, so it lives in the top).
package pingpong_pkg;

  typedef enum logic [1:0] {
    PINGPONG = 2'b00,
    WRAP     = 2'b01,
    ONESHOT  = 2'b10,
    RSVD     = 2'b11
  } mode_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int    RST_LO   = 0;
  localparam int    RST_STEP = 1;
  localparam mode_t RST_MODE = PINGPONG;

endpackage

// File: rtl/pingpong_next.sv
// Combinational next-state for the counter: given current count/direction,
// active config and flip, produce next count, next direction and done-set.
// Ports: count, dir, lo, hi, step, mode, flip in; next_count, next_dir, done_set out.
module pingpong_next
  import pingpong_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] count,
  input  logic             dir,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] step,
  input  mode_t            mode,
  input  logic             flip,
  output logic [WIDTH-1:0] next_count,
  output logic             next_dir,
  output logic             done_set
);

  // One extra bit keeps the up-sum and the down-limit free of wraparound.
  logic [WIDTH:0] up_sum;
  logic [WIDTH:0] dn_lim;
  logic           at_bound;
  logic           eff_dir;

  always_comb begin
    up_sum     = {1'b0, count} + {1'b0, step};
    dn_lim     = {1'b0, lo} + {1'b0, step};
    at_bound   = (count == lo) || (count == hi);
    eff_dir    = dir;
    next_count = count;
    next_dir   = dir;
    done_set   = 1'b0;

    // A flip away from the bounds reverses first, then steps the new way.
    if (mode == PINGPONG && flip && !at_bound) begin
      eff_dir = ~dir;
    end

    case (mode)
      PINGPONG: begin
        if (eff_dir == DIR_UP) begin
          if (up_sum >= {1'b0, hi}) begin
            next_count = hi;
            next_dir   = DIR_DOWN;
          end else begin
            next_count = up_sum[WIDTH-1:0];
            next_dir   = DIR_UP;
          end
        end else begin
          // count - step <= lo  rewritten as  count <= lo + step
          if ({1'b0, count} <= dn_lim) begin
            next_count = lo;
            next_dir   = DIR_UP;
          end else begin
            next_count = count - step;
            next_dir   = DIR_DOWN;
          end
        end
      end
      WRAP: begin
        next_dir = DIR_UP;
        if (count == hi) begin
          next_count = lo;
        end else if (up_sum >= {1'b0, hi}) begin
          next_count = hi;
        end else begin
          next_count = up_sum[WIDTH-1:0];
        end
      end
      ONESHOT: begin
        next_dir = DIR_UP;
        // Once at hi this keeps re-selecting hi, so the count parks there.
        if (up_sum >= {1'b0, hi}) begin
          next_count = hi;
          done_set   = 1'b1;
        end else begin
          next_count = up_sum[WIDTH-1:0];
        end
      end
      default: begin
        next_count = count;
        next_dir   = dir;
      end
    endcase
  end

endmodule

// File: rtl/pingpong_counter_gen.sv
// Programmable sweep generator: bounded up/down counter with pingpong/wrap/oneshot modes.
// Ports: clk, rst; load+lo/hi/step/mode config; hold, flip controls;
// out, dir, max, min, done, cfg_err status (all registered or decoded from registers).
module pingpong_counter_gen
  import pingpong_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] step,
  input  logic [1:0]       mode,
  input  logic             hold,
  input  logic             flip,
  output logic [WIDTH-1:0] out,
  output logic             dir,
  output logic             max,
  output logic             min,
  output logic             done,
  output logic             cfg_err
);

  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] step_q;
  mode_t            mode_q;

  logic [WIDTH-1:0] next_count;
  logic             next_dir;
  logic             done_set;
  logic             cfg_ok;

  assign cfg_ok = (lo < hi) && (step != '0) && (mode_t'(mode) != RSVD);

  pingpong_next #(.WIDTH(WIDTH)) u_next (
    .count      (out),
    .dir        (dir),
    .lo         (lo_q),
    .hi         (hi_q),
    .step       (step_q),
    .mode       (mode_q),
    .flip       (flip),
    .next_count (next_count),
    .next_dir   (next_dir),
    .done_set   (done_set)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out     <= WIDTH'(RST_LO);
      dir     <= DIR_UP;
      done    <= 1'b0;
      cfg_err <= 1'b0;
      lo_q    <= WIDTH'(RST_LO);
      hi_q    <= '1;
      step_q  <= WIDTH'(RST_STEP);
      mode_q  <= RST_MODE;
    end else if (load) begin
      if (cfg_ok) begin
        lo_q    <= lo;
        hi_q    <= hi;
        step_q  <= step;
        mode_q  <= mode_t'(mode);
        out     <= lo;
        dir     <= DIR_UP;
        done    <= 1'b0;
        cfg_err <= 1'b0;
      end else begin
        // Rejected config: keep counting state, skip this cycle's step.
        cfg_err <= 1'b1;
      end
    end else if (!hold) begin
      out  <= next_count;
      dir  <= next_dir;
      done <= done | done_set;
    end
  end

  assign max = (out == hi_q);
  assign min = (out == lo_q);

endmodule

// File: doc/pingpong_counter_gen.md
# pingpong_counter_gen

Parametrised successor to the fixed 4-bit ping-pong counter: a WIDTH-bit up/down counter that bounces between programmable lower and upper bounds. It moves by a programmable step and supports three run modes: ping-pong, wrap and one-shot. It keeps the existing hold/flip controls and max/min/dir status outputs, and adds a load/configuration path with error reporting. It serves as a generic sweep/address generator for datapath blocks.

## Interface
- WIDTH, 4, counter and bound width (≥2)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- load  in  1  latch lo/hi/step/mode into config registers and restart
- lo  in  WIDTH  lower bound (sampled on load)
- hi  in  WIDTH  upper bound (sampled on load)
- step  in  WIDTH  increment magnitude (sampled on load)
- mode  in  2  00 PINGPONG, 01 WRAP, 10 ONESHOT, 11 reserved
- hold  in  1  freeze counter and direction
- flip  in  1  reverse direction, PINGPONG mode only
- out  out  WIDTH  current count
- dir  out  1  direction of the next move: 0 up, 1 down
- max  out  1  out == active hi
- min  out  1  out == active lo
- done  out  1  ONESHOT reached hi (sticky)
- cfg_err  out  1  last load was rejected

## Operation
- Reset values:
  - Counter and status: out=0, dir=0, done=0, cfg_err=0.
  - Config: lo=0, hi=2^WIDTH−1, step=1, mode=PINGPONG.
  - Status flags after reset: min=1, max=0.
- Per-cycle priority: load > hold > flip > normal step.
- load, valid config (lo<hi, step≠0, mode≠11):
  - Latch the config.
  - Set out=lo, dir=0, done=0, cfg_err=0.
- load, invalid config:
  - Config, out and dir are unchanged.
  - Set cfg_err=1.
  - Counting continues with the old config on the following cycles; the load cycle itself does not step.
- hold=1: all state is unchanged, including done.
- Normal step, computed in WIDTH+1 bits so there is no overflow or underflow:
  - Up: if out+step ≥ hi, then out=hi.
    - PINGPONG: dir=1.
    - WRAP: next cycle out=lo, dir stays 0.
    - ONESHOT: done=1 and the counter stops at hi.
  - Otherwise out=out+step.
  - Down (PINGPONG only): if out−step ≤ lo, then out=lo and dir=0. Otherwise out=out−step.
- dir therefore changes in the same cycle out reaches a bound, so dir=1 while out=hi.
- flip=1 (PINGPONG, hold=0), not at a bound: dir toggles, and out moves one step in the new direction in that same cycle (clamped as above).
- flip=1 at out==lo or out==hi: ignored; a normal step is taken.
- flip in WRAP or ONESHOT: ignored.
- ONESHOT after done: out holds at hi, max=1. Only load or rst restarts the counter.
- max and min are decoded from registered state. No combinational path from any input to any output.

## Timing
- All outputs are registered or decoded from registers; there is 1-cycle latency from any input edge.
- load sampled at edge k → out=lo, min=1 after edge k. The first step lands at edge k+1.
- Pure PINGPONG period with step=1 is 2·(hi−lo) cycles.
- Asserting rst mid-count forces reset values immediately, without waiting for clk. Release is synchronous to the next edge.
- A level-held flip re-flips every cycle. Callers pulse it.

## Structure
- Shared package pingpong_pkg holds:
  - mode_t enum (PINGPONG, WRAP, ONESHOT, RSVD);
  - DIR_UP/DIR_DOWN constants;
  - reset-config constants.
- One combinational sub-module, pingpong_next. It takes out, dir, config, flip and mode, and returns next out, next dir and a done-set signal. The top holds only registers, load/validate logic and output decode.

## Test plan
- WIDTH=4, reset, no load: out sweeps 0..15 then 14..0, 31 cycles. dir=1 exactly from out=15 until out=0. min=1 at 0, max=1 at 15.
- load lo=3, hi=12, step=4, PINGPONG: out 3,7,11,12(dir=1),8,4,3(dir=0),7. Then hold for 2 cycles at out=7: out stays 7, dir stays 0.
- load lo=2, hi=9, step=3, WRAP: out 2,5,8,9,2,5; dir always 0. flip pulses throughout have no effect.
- load lo=0, hi=5, step=2, ONESHOT: out 0,2,4,5, then done=1 and out stays 5 for ≥5 cycles. A new load clears done.
- PINGPONG step=1 at out=6 going up, flip pulse: next out=5 with dir=1. A flip at out=0 is ignored: out=1, dir=0.
- load with lo=8, hi=8 while counting: cfg_err=1, count continues under the old config. A valid load clears cfg_err. rst asserted mid-sweep gives out=0 before the next clk edge.
